// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the 24-bit RISC core.
// Owns the program counter, tracks the one-cycle instruction memory read
// latency and buffers fetched {instruction, pc} pairs in a small skid FIFO
// that feeds decode over a valid/ready handshake.
// Optional feature: define FETCH_PERF_EN to add the perf_fetched/perf_stall
// counter ports.
module fetch_unit #(
    parameter logic [23:0] RESET_PC = 24'd0,
    parameter logic [23:0] PC_STEP  = 24'd3,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [23:0] pc,
    input  logic [23:0] inst,
    input  logic        redirect,
    input  logic [23:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [23:0] if_inst,
    output logic [23:0] if_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [23:0]   pc_q;
    logic          inflight;
    logic [23:0]   fifo_inst [DEPTH];
    logic [23:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [23:0]   hold_inst;
    logic [23:0]   hold_pc;
    logic          pop;
    logic          push;
    logic          issue;
    logic [31:0]   occupancy;
    logic [31:0]   limit;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (32'(p) == 32'(DEPTH - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = p + PW'(1);
        end
    endfunction

    assign if_valid = (count != '0);
    assign if_inst  = if_valid ? fifo_inst[head] : hold_inst;
    assign if_pc    = if_valid ? fifo_pc[head]   : hold_pc;

    // Handshake decode and the issue decision: a new address may be sent only
    // if the word it returns is guaranteed a FIFO slot, counting this cycle's pop.
    always_comb begin
        pop       = if_valid & if_ready;
        push      = inflight & ~redirect;
        occupancy = 32'(count) + 32'(inflight);
        limit     = 32'(DEPTH) + 32'(pop);
        issue     = ~redirect & (occupancy < limit);
    end

    // Program counter and in-flight tracking; redirect overrides normal issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            pc_q     <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else if (issue) begin
            pc       <= pc + PC_STEP;
            pc_q     <= pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; a redirect discards everything buffered.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // FIFO storage: the memory word returned this cycle is paired with its address.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[tail] <= inst;
            fifo_pc[tail]   <= pc_q;
        end
    end

    // Remember the last head shown so the outputs hold while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_inst <= '0;
            hold_pc   <= '0;
        end else if (if_valid) begin
            hold_inst <= fifo_inst[head];
            hold_pc   <= fifo_pc[head];
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters survive redirects and wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (if_valid && !if_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

    // The issue rule must keep the FIFO from ever overflowing.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (32'(count) == 32'(DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A directed vector table covers reset, backpressure, redirect and PC wrap;
// a randomized phase is then checked against a queue-based reference model.
// FETCH_PERF_EN, when defined, also enables the performance counter checks.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic        if_ready;
    logic        if_valid;
    logic [23:0] pc;
    logic [23:0] inst;
    logic [23:0] redirect_pc;
    logic [23:0] if_inst;
    logic [23:0] if_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int n_vectors     = 0;
    int n_miscompares = 0;
    int cycle         = 0;

    typedef struct {
        logic        rst;
        logic        redirect;
        logic [23:0] rpc;
        logic        ready;
        logic        exp_valid;
        logic [23:0] exp_if_pc;
        logic [23:0] exp_if_inst;
        logic [23:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [23:0] i;
        logic [23:0] p;
    } entry_t;

    vec_t vecs[27];

    // Reference model state
    entry_t      mq[$];
    logic [23:0] m_pc;
    logic [23:0] m_infl_pc;
    logic        m_infl;
    logic [23:0] m_hold_inst;
    logic [23:0] m_hold_pc;
    logic [31:0] m_fetched;
    logic [31:0] m_stall;

    // Free-running clock
    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(24'd0),
        .PC_STEP (24'd3),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .inst        (inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_inst     (if_inst),
        .if_pc       (if_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    function automatic logic [7:0] im_byte(input logic [23:0] a);
        case (a)
            24'd0:   im_byte = 8'h38;
            24'd1:   im_byte = 8'h01;
            24'd2:   im_byte = 8'h01;
            24'd12:  im_byte = 8'h2A;
            24'd13:  im_byte = 8'h0A;
            24'd14:  im_byte = 8'h0A;
            default: im_byte = (a[7:0] * 8'h1D) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [23:0] mem_word(input logic [23:0] a);
        mem_word = {im_byte(a), im_byte(a + 24'd1), im_byte(a + 24'd2)};
    endfunction

    // Instruction memory: registered read of the address presented each edge.
    always @(posedge clk) begin
        inst <= mem_word(pc);
    end

    function automatic vec_t mk(input logic r, input logic red, input logic [23:0] rpc,
                                input logic rdy, input logic v, input logic [23:0] ip,
                                input logic [23:0] ii, input logic [23:0] p);
        vec_t t;
        t.rst = r; t.redirect = red; t.rpc = rpc; t.ready = rdy;
        t.exp_valid = v; t.exp_if_pc = ip; t.exp_if_inst = ii; t.exp_pc = p;
        return t;
    endfunction

    task automatic applyStimulus(input logic r, input logic red, input logic [23:0] rpc,
                                 input logic rdy);
        @(negedge clk);
        cycle++;
        rst         = r;
        redirect    = red;
        redirect_pc = rpc;
        if_ready    = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, actual, expected);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc        = 24'd0;
        m_infl_pc   = 24'd0;
        m_infl      = 1'b0;
        m_hold_inst = 24'd0;
        m_hold_pc   = 24'd0;
        m_fetched   = 32'd0;
        m_stall     = 32'd0;
    endtask

    task automatic compare_model();
        logic v;
        v = (mq.size() != 0);
        checkOutput("pc", 32'(pc), 32'(m_pc));
        checkOutput("if_valid", 32'(if_valid), 32'(v));
        checkOutput("if_pc", 32'(if_pc), v ? 32'(mq[0].p) : 32'(m_hold_pc));
        checkOutput("if_inst", 32'(if_inst), v ? 32'(mq[0].i) : 32'(m_hold_inst));
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetched", perf_fetched, m_fetched);
        checkOutput("perf_stall", perf_stall, m_stall);
`endif
    endtask

    // Advance the model across one clock edge using the inputs of the cycle.
    task automatic model_advance(input logic r, input logic red, input logic [23:0] rpc,
                                 input logic rdy);
        logic v;
        logic pop;
        int   pending;
        v   = (mq.size() != 0);
        pop = v && rdy;
        if (r) begin
            model_reset();
            return;
        end
        if (pop) m_fetched = m_fetched + 32'd1;
        if (v && !rdy) m_stall = m_stall + 32'd1;
        if (v) begin
            m_hold_inst = mq[0].i;
            m_hold_pc   = mq[0].p;
        end
        if (red) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = rpc;
        end else begin
            pending = mq.size() + int'(m_infl) - int'(pop);
            if (pop) void'(mq.pop_front());
            if (m_infl) mq.push_back('{i: mem_word(m_infl_pc), p: m_infl_pc});
            if (pending < DEPTH) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 24'd3;
                m_infl    = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    initial begin
        logic        r;
        logic        red;
        logic        rdy;
        logic [23:0] rpc;

        vecs[0]  = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 24'd0, 24'd0, 24'd0);
        vecs[1]  = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 24'd0, 24'd0, 24'd3);
        vecs[2]  = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 24'd0, 24'h380101, 24'd6);
        vecs[3]  = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 24'd3, mem_word(24'd3), 24'd9);
        vecs[4]  = mk(1'b0, 1'b0, 24'd0, 1'b0, 1'b1, 24'd6, mem_word(24'd6), 24'd12);
        vecs[5]  = mk(1'b0, 1'b0, 24'd0, 1'b0, 1'b1, 24'd6, mem_word(24'd6), 24'd12);
        vecs[6]  = mk(1'b0, 1'b0, 24'd0, 1'b0, 1'b1, 24'd6, mem_word(24'd6), 24'd12);
        vecs[7]  = mk(1'b0, 1'b0, 24'd0, 1'b0, 1'b1, 24'd6, mem_word(24'd6), 24'd12);
        vecs[8]  = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 24'd6, mem_word(24'd6), 24'd12);
        vecs[9]  = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 24'd9, mem_word(24'd9), 24'd15);
        vecs[10] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 24'd12, 24'h2A0A0A, 24'd18);
        vecs[11] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 24'd15, mem_word(24'd15), 24'd21);
        vecs[12] = mk(1'b0, 1'b0, 24'd0, 1'b0, 1'b1, 24'd18, mem_word(24'd18), 24'd24);
        vecs[13] = mk(1'b0, 1'b1, 24'd12, 1'b0, 1'b1, 24'd18, mem_word(24'd18), 24'd24);
        vecs[14] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 24'd18, mem_word(24'd18), 24'd12);
        vecs[15] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 24'd18, mem_word(24'd18), 24'd15);
        vecs[16] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 24'd12, 24'h2A0A0A, 24'd18);
        vecs[17] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 24'd15, mem_word(24'd15), 24'd21);
        vecs[18] = mk(1'b0, 1'b1, 24'hFFFFFD, 1'b1, 1'b1, 24'd18, mem_word(24'd18), 24'd24);
        vecs[19] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 24'd18, mem_word(24'd18), 24'hFFFFFD);
        vecs[20] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 24'd18, mem_word(24'd18), 24'd0);
        vecs[21] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 24'hFFFFFD, mem_word(24'hFFFFFD), 24'd3);
        vecs[22] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 24'd0, 24'h380101, 24'd6);
        vecs[23] = mk(1'b1, 1'b1, 24'd30, 1'b1, 1'b1, 24'd3, mem_word(24'd3), 24'd9);
        vecs[24] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 24'd0, 24'd0, 24'd0);
        vecs[25] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 24'd0, 24'd0, 24'd3);
        vecs[26] = mk(1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 24'd0, 24'h380101, 24'd6);

        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 24'd0;
        if_ready    = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] directed vector table");
        for (int k = 0; k < 27; k++) begin
            applyStimulus(vecs[k].rst, vecs[k].redirect, vecs[k].rpc, vecs[k].ready);
            checkOutput("tbl_if_valid", 32'(if_valid), 32'(vecs[k].exp_valid));
            checkOutput("tbl_if_pc", 32'(if_pc), 32'(vecs[k].exp_if_pc));
            checkOutput("tbl_if_inst", 32'(if_inst), 32'(vecs[k].exp_if_inst));
            checkOutput("tbl_pc", 32'(pc), 32'(vecs[k].exp_pc));
`ifdef FETCH_PERF_EN
            if (k == 12) begin
                checkOutput("tbl_perf_fetched", perf_fetched, 32'd6);
                checkOutput("tbl_perf_stall", perf_stall, 32'd4);
            end
            if (k == 16) begin
                checkOutput("tbl_perf_fetched", perf_fetched, 32'd6);
                checkOutput("tbl_perf_stall", perf_stall, 32'd6);
            end
`endif
        end

        $display("[TB] randomized phase against reference model");
        applyStimulus(1'b1, 1'b0, 24'd0, 1'b0);
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            r   = ($urandom_range(0, 249) == 0);
            red = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                rpc = 24'hFFFFFD - 24'(3 * $urandom_range(0, 3));
            end else begin
                rpc = 24'($urandom);
            end
            applyStimulus(r, red, rpc, rdy);
            compare_model();
            model_advance(r, red, rpc, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
